seg7_scan_encoder: RTL and testbench

Reads a multiplexed, active-low 7-segment display bus (segment lines plus per-digit select lines) and rebuilds the BCD value of every digit. It is the reader for the display path that the 7-segment decoders drive. It sits beside the display driver in the clock top level and feeds self-check and readback logic. Segment input changes are debounced by a settle counter before each capture.

---
 rtl/seg7_scan_encoder.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_encoder.sv
// seg7_scan_encoder: rebuilds per-digit BCD codes from a multiplexed,
// active-low 7-segment bus, debouncing each digit before it is captured.
// Ports: clk, reset (sync, active-high), segIn[6:0] (a..g, active-low),
//   digitSel (active-low one-cold), bcdOut (4 bits per digit), digitValid,
//   update (capture pulse), frameDone (all digits seen), patternErr (sticky),
//   timeout (sticky watchdog, only when SCAN_TIMEOUT_EN is defined).
module seg7_scan_encoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segIn,
  input  logic [NUM_DIGITS-1:0]   digitSel,
  output logic [4*NUM_DIGITS-1:0] bcdOut,
  output logic [NUM_DIGITS-1:0]   digitValid,
  output logic                    update,
  output logic                    frameDone,
  output logic                    patternErr
`ifdef SCAN_TIMEOUT_EN
  ,
  output logic                    timeout
`endif
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ZW = $clog2(NUM_DIGITS + 1);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t                state;
  logic [6:0]            seg_q;
  logic [6:0]            seg_p;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [NUM_DIGITS-1:0] sel_p;
  logic [CW-1:0]         cnt;
  logic [NUM_DIGITS-1:0] mask;

  logic [ZW-1:0]         nzero;
  logic [IW-1:0]         idx;
  logic                  sel_ok;
  logic                  same;
  logic                  stable;
  logic                  cap;
  logic [NUM_DIGITS-1:0] cap_bit;
  logic [3:0]            code;
  logic                  bad;

  // Count the low selects and remember where the (last) one sits.
  always_comb begin
    nzero = '0;
    idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel_q[i]) begin
        nzero = nzero + ZW'(1);
        idx   = IW'(i);
      end
    end
  end

  assign sel_ok  = (nzero == ZW'(1));
  assign same    = (seg_q == seg_p) && (sel_q == sel_p);
  assign stable  = (STABLE_CYCLES == 1) ||
                   (cnt == CW'(STABLE_CYCLES - 1));
  assign cap     = (state == SETTLE) && sel_ok && same && stable;
  assign cap_bit = cap ? (NUM_DIGITS'(1) << idx) : '0;

  always_comb begin
    code = 4'hE;
    bad  = 1'b0;
    case (seg_q)
      7'h40:   code = 4'd0;
      7'h79:   code = 4'd1;
      7'h24:   code = 4'd2;
      7'h30:   code = 4'd3;
      7'h19:   code = 4'd4;
      7'h12:   code = 4'd5;
      7'h02:   code = 4'd6;
      7'h78:   code = 4'd7;
      7'h00:   code = 4'd8;
      7'h10:   code = 4'd9;
      7'h7F:   code = 4'hF;
      default: bad  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mask       <= '0;
      seg_q      <= '1;
      seg_p      <= '1;
      sel_q      <= '1;
      sel_p      <= '1;
      bcdOut     <= '1;
      digitValid <= '0;
      update     <= 1'b0;
      frameDone  <= 1'b0;
      patternErr <= 1'b0;
    end else begin
      seg_q      <= segIn;
      sel_q      <= digitSel;
      seg_p      <= seg_q;
      sel_p      <= sel_q;
      update     <= cap;
      digitValid <= digitValid | cap_bit;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_bit[i]) bcdOut[4*i +: 4] <= code;
      end
      if (cap && bad) patternErr <= 1'b1;
      // A full mask fires frameDone and clears; a capture in the
      // same cycle still lands in the fresh mask.
      frameDone <= &mask;
      mask      <= ((&mask) ? '0 : mask) | cap_bit;
      unique case (state)
        IDLE: begin
          if (sel_ok) begin
            state <= SETTLE;
            cnt   <= CW'(1);
          end
        end
        SETTLE: begin
          if (!sel_ok) begin
            state <= IDLE;
          end else if (!same) begin
            cnt <= CW'(1);
          end else if (stable) begin
            state <= HOLD;
          end else if (cnt < CW'(STABLE_CYCLES)) begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (!sel_ok) begin
            state <= IDLE;
          end else if (!same) begin
            state <= SETTLE;
            cnt   <= CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else if (cap) begin
      wd <= '0;
    end else if (wd != TW'(TIMEOUT_CYCLES)) begin
      wd <= wd + TW'(1);
      if (wd == TW'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// tb_seg7_scan_encoder: scoreboard bench for seg7_scan_encoder.
// Directed scenarios plus randomized scanning against a run-length model.
module tb_seg7_scan_encoder;

  localparam int N = 4;
  localparam int S = 4;
  localparam logic [6:0] PAT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [6:0]   segIn = '1;
  logic [N-1:0] digitSel = '1;
  logic [4*N-1:0] bcdOut;
  logic [N-1:0] digitValid;
  logic         update;
  logic         frameDone;
  logic         patternErr;
`ifdef SCAN_TIMEOUT_EN
  logic         timeout;
`endif

  always #5 clk = ~clk;

  seg7_scan_encoder #(
    .NUM_DIGITS(N),
    .STABLE_CYCLES(S),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .segIn(segIn),
    .digitSel(digitSel),
    .bcdOut(bcdOut),
    .digitValid(digitValid),
    .update(update),
    .frameDone(frameDone),
    .patternErr(patternErr)
`ifdef SCAN_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  typedef struct {
    logic [4*N-1:0] bcd;
    logic [N-1:0]   val;
    logic           perr;
    logic           fd;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int upd_seen = 0;
  int fd_seen = 0;
  int pushed = 0;

  // Reference model state: a capture happens on the edge after the
  // S-th consecutive identical sample with exactly one select low.
  logic [4*N-1:0] m_bcd = '1;
  logic [N-1:0]   m_val = '0;
  logic           m_perr = 1'b0;
  logic [N-1:0]   m_mask = '0;
  logic [6:0]     p_seg = '1;
  logic [N-1:0]   p_sel = '1;
  int             run = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_code(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (s == PAT[i]) return 4'(i);
    return (s == 7'h7F) ? 4'hF : 4'hE;
  endfunction

  function automatic int zeros(input logic [N-1:0] sel, output int pos);
    int n = 0;
    pos = 0;
    for (int i = 0; i < N; i++)
      if (!sel[i]) begin n++; pos = i; end
    return n;
  endfunction

  task automatic model_edge(input logic rst, input logic [N-1:0] sel,
                            input logic [6:0] seg);
    exp_t e;
    int pos;
    int nz;
    logic [3:0] c;
    if (rst) begin
      m_bcd = '1; m_val = '0; m_perr = 1'b0; m_mask = '0;
      p_seg = '1; p_sel = '1; run = 0;
      return;
    end
    if (run == S) begin
      nz = zeros(p_sel, pos);
      c = ref_code(p_seg);
      m_bcd[4*pos +: 4] = c;
      m_val[pos] = 1'b1;
      if (c == 4'hE) m_perr = 1'b1;
      m_mask[pos] = 1'b1;
      e.fd = &m_mask;
      if (e.fd) m_mask = '0;
      e.bcd = m_bcd; e.val = m_val; e.perr = m_perr;
      q.push_back(e);
      pushed++;
    end
    nz = zeros(sel, pos);
    if (nz != 1) run = 0;
    else if (run > 0 && seg == p_seg && sel == p_sel) begin
      if (run <= S) run++;
    end else run = 1;
    p_seg = seg;
    p_sel = sel;
  endtask

  // Monitor: pops an expectation whenever the DUT pulses update.
  logic fd_pending = 1'b0;
  logic fd_exp = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (frameDone) fd_seen++;
    if (fd_pending) begin
      chk("frameDone", 64'(frameDone), 64'(fd_exp));
      fd_pending = 1'b0;
    end else if (frameDone) begin
      chk("frameDone_unexpected", 64'(frameDone), 64'(0));
    end
    if (update) begin
      upd_seen++;
      if (q.size() == 0) begin
        chk("update_unexpected", 64'(update), 64'(0));
      end else begin
        e = q.pop_front();
        chk("bcdOut", 64'(bcdOut), 64'(e.bcd));
        chk("digitValid", 64'(digitValid), 64'(e.val));
        chk("patternErr", 64'(patternErr), 64'(e.perr));
        fd_pending = 1'b1;
        fd_exp = e.fd;
      end
    end
  end

  task automatic step(input logic [N-1:0] sel, input logic [6:0] seg,
                      input logic rst);
    digitSel = sel;
    segIn = seg;
    reset = rst;
    @(posedge clk);
    model_edge(rst, sel, seg);
    #1;
  endtask

  task automatic hold(input logic [N-1:0] sel, input logic [6:0] seg,
                      input int n);
    for (int i = 0; i < n; i++) step(sel, seg, 1'b0);
  endtask

  task automatic do_reset();
    step('1, '1, 1'b1);
  endtask

  int u0;
  int f0;
  logic [N-1:0] rs;
  logic [6:0] rg;
  int r;

  initial begin
    // Reset values
    do_reset();
    chk("rst_bcdOut", 64'(bcdOut), 64'(16'hFFFF));
    chk("rst_digitValid", 64'(digitValid), 64'(0));
    chk("rst_update", 64'(update), 64'(0));
    chk("rst_frameDone", 64'(frameDone), 64'(0));
    chk("rst_patternErr", 64'(patternErr), 64'(0));

    // Single digit capture of 2
    u0 = upd_seen;
    hold(4'b1110, 7'h24, 10);
    chk("t1_updates", 64'(upd_seen - u0), 64'(1));
    chk("t1_digit0", 64'(bcdOut[3:0]), 64'(2));
    chk("t1_valid", 64'(digitValid), 64'(4'b0001));
    chk("t1_perr", 64'(patternErr), 64'(0));

    // Toggle before settling: only 3 gets captured, S edges after toggle
    do_reset();
    u0 = upd_seen;
    hold(4'b1110, 7'h24, 2);
    hold(4'b1110, 7'h30, S);
    chk("t2_no_early", 64'(upd_seen - u0), 64'(0));
    step(4'b1110, 7'h30, 1'b0);
    chk("t2_update", 64'(update), 64'(1));
    chk("t2_digit0", 64'(bcdOut[3:0]), 64'(3));
    hold(4'b1110, 7'h30, 4);
    chk("t2_updates", 64'(upd_seen - u0), 64'(1));

    // Full frame scan
    do_reset();
    u0 = upd_seen;
    f0 = fd_seen;
    hold(4'b1110, PAT[9], 6);
    hold(4'b1101, PAT[5], 6);
    hold(4'b1011, PAT[0], 6);
    hold(4'b0111, PAT[7], 6);
    hold('1, '1, 2);
    chk("t3_bcdOut", 64'(bcdOut), 64'(16'h7059));
    chk("t3_updates", 64'(upd_seen - u0), 64'(4));
    chk("t3_frames", 64'(fd_seen - f0), 64'(1));

    // Bad pattern is sticky
    do_reset();
    hold(4'b1101, 7'h2A, 6);
    chk("t4_digit1", 64'(bcdOut[7:4]), 64'(4'hE));
    chk("t4_perr", 64'(patternErr), 64'(1));
    hold(4'b1110, PAT[4], 6);
    chk("t4_digit0", 64'(bcdOut[3:0]), 64'(4));
    chk("t4_perr_sticky", 64'(patternErr), 64'(1));
    do_reset();
    chk("t4_perr_reset", 64'(patternErr), 64'(0));

    // Bad selects, then reset on the capture edge
    u0 = upd_seen;
    hold(4'b1100, PAT[1], 20);
    hold(4'b1111, PAT[1], 20);
    chk("t5_badsel", 64'(upd_seen - u0), 64'(0));
    hold(4'b1011, PAT[6], S);
    step(4'b1011, PAT[6], 1'b1);
    chk("t5_update", 64'(update), 64'(0));
    chk("t5_bcdOut", 64'(bcdOut), 64'(16'hFFFF));
    chk("t5_valid", 64'(digitValid), 64'(0));
    chk("t5_frameDone", 64'(frameDone), 64'(0));
    chk("t5_updates", 64'(upd_seen - u0), 64'(0));

    // Randomized scanning
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) < 8)
        rs = ~(N'(1) << $urandom_range(0, N - 1));
      else
        rs = N'($urandom());
      r = int'($urandom_range(0, 9));
      if (r < 7) rg = PAT[$urandom_range(0, 9)];
      else if (r == 7) rg = 7'h7F;
      else rg = 7'($urandom());
      hold(rs, rg, int'($urandom_range(1, 8)));
    end
    hold('1, '1, 3);

`ifdef SCAN_TIMEOUT_EN
    do_reset();
    hold('1, '1, 49);
    chk("t6_before", 64'(timeout), 64'(0));
    step('1, '1, 1'b0);
    chk("t6_at50", 64'(timeout), 64'(1));
    hold('1, '1, 10);
    u0 = upd_seen;
    hold(4'b1110, PAT[8], 6);
    chk("t6_capture", 64'(upd_seen - u0), 64'(1));
    chk("t6_sticky", 64'(timeout), 64'(1));
    hold('1, '1, 2);
`endif

    chk("queue_drained", 64'(q.size()), 64'(0));
    chk("update_count", 64'(upd_seen), 64'(pushed));
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
